// File: rtl/bit_scan_serial.sv
// bit_scan_serial: latches a word on start and emits the index of each set bit,
// lowest first, one per accepted valid/ready handshake. It also reports whether
// the latched word was zero and how many indices have been accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   inA        word to scan, sampled on an accepted start
//   start      scan request, accepted only in IDLE
//   busy       high in SCAN and DONE
//   idx_out    lowest remaining set-bit index (valid with idx_valid)
//   idx_valid  idx_out holds a valid index
//   idx_ready  consumer accepts idx_out this cycle
//   done       one-cycle pulse at end of scan
//   flag       latched word was zero
//   count      indices accepted in the current or last scan
module bit_scan_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDXW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic             start,
  output logic             busy,
  output logic [IDXW-1:0]  idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             done,
  output logic             flag,
  output logic [IDXW:0]    count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] shadow_cleared;
  logic [IDXW:0]    count_next;
  logic             flag_next;
  logic [IDXW-1:0]  low_idx;

  // Priority encoder: the downward loop lets the lowest set bit win.
  always_comb begin
    low_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (shadow[i]) low_idx = IDXW'(i);
    end
  end

  // x & (x-1) drops exactly the lowest set bit, the one low_idx points at.
  assign shadow_cleared = shadow & (shadow - WIDTH'(1));

  // Next-state and datapath update.
  always_comb begin
    state_next  = state;
    shadow_next = shadow;
    count_next  = count;
    flag_next   = flag;
    case (state)
      IDLE: begin
        if (start) begin
          shadow_next = inA;
          count_next  = '0;
          flag_next   = (inA == '0);
          state_next  = (inA == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (idx_ready) begin
          shadow_next = shadow_cleared;
          count_next  = count + (IDXW+1)'(1);
          if (shadow_cleared == '0) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      shadow <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      state  <= state_next;
      shadow <= shadow_next;
      count  <= count_next;
      flag   <= flag_next;
    end
  end

  // Outputs decoded from registered state and shadow only.
  assign busy      = (state != IDLE);
  assign idx_valid = (state == SCAN);
  assign done      = (state == DONE);
  assign idx_out   = low_idx;

endmodule

// File: tb/tb_bit_scan_serial.sv
// tb_bit_scan_serial: scoreboard bench for bit_scan_serial. Expected indices are
// queued from a reference decomposition when a start is driven and popped as the
// DUT hands them out.
module tb_bit_scan_serial;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDXW  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] inA;
  logic             start;
  logic             busy;
  logic [IDXW-1:0]  idx_out;
  logic             idx_valid;
  logic             idx_ready;
  logic             done;
  logic             flag;
  logic [IDXW:0]    count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bit_scan_serial #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .inA       (inA),
    .start     (start),
    .busy      (busy),
    .idx_out   (idx_out),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .done      (done),
    .flag      (flag),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one scan. rpat gives idx_ready per scan cycle (LSB first) for plen
  // cycles, then ready stays high. exp_lat (if > 0) is the cycle, counted from
  // the first cycle after start acceptance, in which done must pulse.
  // abort_after (if > 0) returns early once that many indices were taken.
  task automatic run_scan(input logic [31:0] word, input logic [7:0] rpat, input int plen,
                          input int exp_lat, input bit mid_start, input int abort_after);
    int c;
    int acc;
    int k;
    bit fin;
    bit aborted;
    k = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (word[i]) begin
        exp_q.push_back(i);
        k++;
      end
    end
    @(posedge clk); #1;
    start = 1'b1;
    inA = word;
    idx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    inA = '0;
    c = 1;
    acc = 0;
    fin = 1'b0;
    aborted = 1'b0;
    idx_ready = (plen > 0) ? rpat[0] : 1'b1;
    while (!fin) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("count_run", 32'(count), 32'(acc));
      if (idx_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_idx", 32'd1, 32'd0);
        end else begin
          chk("idx", 32'(idx_out), 32'(exp_q[0]));
          if (idx_ready) begin
            void'(exp_q.pop_front());
            acc++;
          end
        end
      end
      if (done) begin
        chk("done_flag", 32'(flag), 32'(word == 32'd0));
        chk("done_count", 32'(count), 32'(k));
        chk("done_left", 32'(exp_q.size()), 32'd0);
        chk("done_novalid", 32'(idx_valid), 32'd0);
        if (exp_lat > 0) chk("latency", 32'(c), 32'(exp_lat));
        fin = 1'b1;
      end else if (abort_after > 0 && acc == abort_after) begin
        aborted = 1'b1;
        fin = 1'b1;
      end else if (c >= 100) begin
        chk("timeout", 32'd1, 32'd0);
        fin = 1'b1;
      end else begin
        @(posedge clk); #1;
        c++;
        idx_ready = (c <= plen) ? rpat[c-1] : 1'b1;
        if (mid_start) begin
          start = (c == 2);
          inA = (c == 2) ? 32'h1 : 32'h0;
        end
      end
    end
    idx_ready = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_count", 32'(count), 32'(k));
      chk("idle_flag", 32'(flag), 32'(word == 32'd0));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(idx_valid), 32'd0);
    chk({tag, "_idx"}, 32'(idx_out), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_flag"}, 32'(flag), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    logic [31:0] rw;
    logic [7:0]  rp;
    rst = 1'b1;
    start = 1'b0;
    idx_ready = 1'b0;
    inA = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_scan(32'h0000_0000, 8'h00, 0, 1, 1'b0, 0);
    run_scan(32'h8000_0000, 8'h00, 0, 2, 1'b0, 0);
    run_scan(32'hFFFF_FFFF, 8'h00, 0, 33, 1'b0, 0);
    run_scan(32'h0000_0105, 8'b0001_1001, 5, 6, 1'b0, 0);
    run_scan(32'h0000_F000, 8'h00, 0, 5, 1'b1, 0);

    // Mid-scan reset: outputs must clear without waiting for a clock edge.
    run_scan(32'h0F00_0000, 8'h00, 0, 0, 1'b0, 2);
    #1 rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run_scan(32'h0000_0002, 8'h00, 0, 2, 1'b0, 0);

    for (int t = 0; t < 4; t++) begin
      rw = $urandom;
      rp = 8'($urandom);
      run_scan(rw, rp, 8, 0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_scan_serial.md
Name: bit_scan_serial

Overview:
Sequential bit decomposer for the ALU datapath, the inverse of the 32-bit OR/zero-flag logic unit. That unit merges bits into one word and reports all-zero. This block takes a word and emits the index of each set bit, lowest first, one per accepted handshake. It also reports the zero flag and the population count. It sits downstream of the ALU result bus and feeds mask/register-list consumers.

Parameters:
WIDTH, 32, data word width (power of two, >= 2)
IDXW, 5, index width, equal to log2(WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
inA  input  WIDTH  word to scan; sampled only on an accepted start
start  input  1  request a scan; accepted only in IDLE
busy  output  1  high in SCAN and DONE; start is ignored while high
idx_out  output  IDXW  index of the lowest remaining set bit; valid only when idx_valid is high
idx_valid  output  1  idx_out holds a valid index
idx_ready  input  1  consumer accepts idx_out this cycle
done  output  1  one-cycle pulse at end of scan
flag  output  1  1 if the latched word was zero
count  output  IDXW+1  number of indices accepted in the current or last scan

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - state=IDLE, shadow register=0
  - busy=0, idx_valid=0, idx_out=0, done=0, flag=0, count=0
- Reset asserted mid-scan aborts the scan immediately. The index in flight is lost.
- FSM has three states: IDLE, SCAN, DONE. All outputs are registered, or decoded from registered state and shadow only. There is no combinational path from any input to any output.
- IDLE, when start=1:
  - shadow<=inA, count<=0, flag<=(inA==0)
  - If inA!=0, go to SCAN. Otherwise go to DONE.
- IDLE, when start=0: hold. count and flag keep the last scan's values.
- SCAN:
  - idx_valid=1.
  - idx_out = index of the lowest set bit of shadow, from a priority encoder. Bit 0 has highest priority.
  - On idx_valid & idx_ready: clear that bit in shadow and increment count.
  - If shadow becomes 0 after the clear, go to DONE. Otherwise stay in SCAN.
  - Without idx_ready, idx_out and idx_valid hold stable. No index is skipped or repeated.
- DONE: done=1 and idx_valid=0 for exactly one cycle, then go to IDLE. start is ignored in DONE.
- Latency and throughput:
  - start is accepted at edge N. idx_valid is high in the cycle after edge N, with the first index.
  - With idx_ready held high, one index is accepted per cycle.
  - Scanning k set bits takes k SCAN cycles plus one DONE cycle.
  - A zero word goes straight to DONE, so done pulses in the cycle after start.
- Width rules:
  - count is IDXW+1 bits wide so it holds WIDTH exactly (32 for all ones). It never wraps.
  - idx_out ranges from 0 to WIDTH-1.
- Simultaneous events:
  - start during busy is dropped. It is not queued.
  - idx_ready outside SCAN is ignored.
  - The last bit accepted in SCAN and the DONE transition happen on the same edge.

Test Plan:
- Reset, then start with inA=0x00000000:
  - busy=1, idx_valid never asserts
  - done pulses 1 cycle after start
  - flag=1, count=0
- inA=0x80000000 with idx_ready=1:
  - one index, idx_out=31
  - done on the next cycle
  - flag=0, count=1
- inA=0xFFFFFFFF with idx_ready=1:
  - idx_out steps 0,1,…,31 on 32 consecutive cycles, then done
  - count=32
- inA=0x00000105 with idx_ready toggling 1,0,0,1,1:
  - indices 0, 8, 2 are not produced in that order; the required sequence is 0, 2, 8
  - idx_out stays stable while ready=0
  - count=3
- During a scan of 0x0000F000, pulse start with inA=0x1:
  - second start is ignored
  - indices 12..15 are produced, count=4
- Assert rst for 1 cycle after 2 of 4 indices of 0x0F000000:
  - all outputs go to 0 immediately and state is IDLE
  - a new start with inA=0x2 yields idx_out=1, count=1
